lisa_qspi_resp: RTL and testbench

LISA_QSPI_RESP -- requirements
Module: lisa_qspi_resp

---
 rtl/lisa_qspi_resp.sv | 249 ++++++++++++++++++++++++
 tb/tb_lisa_qspi_resp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lisa_qspi_resp.sv
// QSPI target responder: decodes 0x03 / 0xEB / 0x38 from an asynchronous SPI mode-0
// initiator and turns them into single-clk byte read/write strobes on a local memory port.
module lisa_qspi_resp #(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_n,
  input  logic                 sck,
  input  logic [3:0]           dq_in,
  output logic [3:0]           dq_out,
  output logic [3:0]           dq_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_e;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST_S = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST_Q = CNT_W'(ADDR_BITS / 4 - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST  = CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  // Synchronizers
  logic       ce_s1_q, ce_s2_q;
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic [3:0] dq_s1_q, dq_s2_q;
  logic       sck_rise, sck_fall;

  // The ce_n synchronizer resets to "selected" so a transaction already in flight
  // at reset release is not picked up halfway; a genuine high must be seen first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_s1_q    <= 1'b0;
      ce_s2_q    <= 1'b0;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      dq_s1_q    <= '0;
      dq_s2_q    <= '0;
    end else begin
      ce_s1_q    <= ce_n;
      ce_s2_q    <= ce_s1_q;
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      dq_s1_q    <= dq_in;
      dq_s2_q    <= dq_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;

  // Protocol state
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [7:0]           cmd_q, cmd_d, cmd_next;
  logic                 quad_q, quad_d;
  logic                 wr_mode_q, wr_mode_d;
  logic                 armed_q, armed_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 rd_dly_q;
  logic                 wr_q, wr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [3:0]           nib_q, nib_d;
  logic [7:0]           rbyte_q, rbyte_d;
  logic [3:0]           dq_out_q, dq_out_d;
  logic [3:0]           dq_oe_q, dq_oe_d;
  logic                 rd_last;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cmd_next = {cmd_q[6:0], dq_s2_q[0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    quad_d    = quad_q;
    wr_mode_d = wr_mode_q;
    armed_d   = armed_q | ce_s2_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    nib_d     = nib_q;
    rbyte_d   = rbyte_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = dq_oe_q;
    rd_last   = 1'b0;

    // Post-write increment and read-data capture run independently of the state.
    if (wr_q)     addr_d  = addr_q + 1'b1;
    if (rd_dly_q) rbyte_d = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (!ce_s2_q && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (sck_rise) begin
          cmd_d = cmd_next;
          cnt_d = cnt_inc;
          if (cnt_q == CMD_LAST) begin
            cnt_d = '0;
            case (cmd_next)
              8'h03:   begin quad_d = 1'b0; wr_mode_d = 1'b0; state_d = ADDR; end
              8'hEB:   begin quad_d = 1'b1; wr_mode_d = 1'b0; state_d = ADDR; end
              8'h38:   begin quad_d = 1'b1; wr_mode_d = 1'b1; state_d = ADDR; end
              default: state_d = IGNORE;
            endcase
          end
        end
      end
      ADDR: begin
        if (sck_rise) begin
          addr_d = quad_q ? {addr_q[ADDR_BITS-5:0], dq_s2_q}
                          : {addr_q[ADDR_BITS-2:0], dq_s2_q[0]};
          cnt_d  = cnt_inc;
          if (cnt_q == (quad_q ? ADDR_LAST_Q : ADDR_LAST_S)) begin
            cnt_d = '0;
            if (wr_mode_q) begin
              state_d = WDATA;
            end else begin
              rd_d    = 1'b1;
              state_d = (quad_q && DUMMY_CYCLES != 0) ? DUMMY : RDATA;
            end
          end
        end
      end
      DUMMY: begin
        if (sck_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        if (sck_fall) begin
          if (quad_q) begin
            dq_oe_d  = 4'b1111;
            dq_out_d = cnt_q[0] ? rbyte_q[3:0] : rbyte_q[7:4];
            rd_last  = cnt_q[0];
          end else begin
            dq_oe_d  = 4'b0010;
            dq_out_d = {2'b00, rbyte_q[~cnt_q[2:0]], 1'b0};
            rd_last  = (cnt_q[2:0] == 3'd7);
          end
          cnt_d = rd_last ? '0 : cnt_inc;
          if (rd_last) begin
            addr_d = addr_q + 1'b1;
            rd_d   = 1'b1;
          end
        end
      end
      WDATA: begin
        if (sck_rise) begin
          if (!cnt_q[0]) begin
            nib_d = dq_s2_q;
            cnt_d = CNT_W'(1);
          end else begin
            wdata_d = {nib_q, dq_s2_q};
            wr_d    = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    if (ce_s2_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      cmd_d   = '0;
      nib_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end

    if (state_d != RDATA) begin
      dq_oe_d  = '0;
      dq_out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      quad_q    <= 1'b0;
      wr_mode_q <= 1'b0;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      rd_dly_q  <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      nib_q     <= '0;
      rbyte_q   <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      quad_q    <= quad_d;
      wr_mode_q <= wr_mode_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      rd_dly_q  <= rd_q;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      nib_q     <= nib_d;
      rbyte_q   <= rbyte_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lisa_qspi_resp.sv
// Directed bench for lisa_qspi_resp: drives QSPI transactions bit by bit and checks
// pins and memory strobes against hand-computed values.
module tb_lisa_qspi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_n;
  logic        sck;
  logic [3:0]  dq_in;
  logic [3:0]  dq_out;
  logic [3:0]  dq_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_wr;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [23:0] rd_log[$];
  logic [23:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  int          both_cnt = 0;
  int          oe_bad   = 0;
  logic        oe_watch = 1'b0;

  always #5 clk = ~clk;

  lisa_qspi_resp #(.ADDR_BITS(24), .DUMMY_CYCLES(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce_n      (ce_n),
    .sck       (sck),
    .dq_in     (dq_in),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  function automatic logic [7:0] mem_lookup(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000040: return 8'h3C;
      24'h000100: return 8'h12;
      24'h000101: return 8'h34;
      default:    return 8'h00;
    endcase
  endfunction

  // Memory model: data valid the clk after the strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_lookup(mem_addr);

  always @(negedge clk) begin
    if (mem_rd) rd_log.push_back(mem_addr);
    if (mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    if (mem_rd && mem_wr) both_cnt++;
    if (oe_watch && dq_oe !== 4'b0000) oe_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_cycle(input logic [3:0] d);
    sck   = 1'b0;
    dq_in = d;
    wclk(6);
    sck   = 1'b1;
    wclk(6);
  endtask

  task automatic send_serial(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) sck_cycle({3'b000, v[i]});
  endtask

  task automatic send_quad(input logic [31:0] v, input int nnib);
    for (int i = nnib - 1; i >= 0; i--) sck_cycle(v[4*i +: 4]);
  endtask

  task automatic start_txn();
    sck  = 1'b0;
    ce_n = 1'b0;
    wclk(8);
  endtask

  task automatic stop_txn();
    sck  = 1'b0;
    wclk(6);
    ce_n = 1'b1;
    wclk(10);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    oe_bad = 0;
  endtask

  task automatic read_serial(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sck = 1'b0;
      wclk(6);
      got[i] = dq_out[1];
      chk({tag, "_bit"}, {31'd0, dq_out[1]}, {31'd0, exp[i]});
      chk({tag, "_oe"}, {28'd0, dq_oe}, 32'h2);
      sck = 1'b1;
      wclk(6);
    end
    chk({tag, "_byte"}, {24'd0, got}, {24'd0, exp});
  endtask

  task automatic read_quad(input string tag, input logic [3:0] exp);
    sck = 1'b0;
    wclk(6);
    chk({tag, "_nib"}, {28'd0, dq_out}, {28'd0, exp});
    chk({tag, "_oe"}, {28'd0, dq_oe}, 32'hF);
    sck = 1'b1;
    wclk(6);
  endtask

  initial begin
    rst_n = 1'b0;
    ce_n  = 1'b1;
    sck   = 1'b0;
    dq_in = 4'h0;
    wclk(3);
    chk("rst_dq_oe", {28'd0, dq_oe}, 32'h0);
    chk("rst_dq_out", {28'd0, dq_out}, 32'h0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 32'h0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'h0);
    rst_n = 1'b1;
    wclk(8);
    clear_logs();

    // Serial read 0x03 @0x10 -> 0xA5
    start_txn();
    send_serial(32'h03, 8);
    send_serial(32'h000010, 24);
    read_serial("sread", 8'hA5);
    stop_txn();
    chk("sread_rd_count", rd_log.size(), 2);
    chk("sread_rd_addr0", {8'd0, rd_log[0]}, 32'h10);
    chk("sread_rd_addr1", {8'd0, rd_log[1]}, 32'h11);
    chk("sread_oe_idle", {28'd0, dq_oe}, 32'h0);
    clear_logs();

    // Quad read 0xEB @0x100, 6 dummy, bytes 0x12 0x34
    start_txn();
    send_serial(32'hEB, 8);
    send_quad(32'h000100, 6);
    for (int i = 0; i < 6; i++) sck_cycle(4'h0);
    read_quad("qread0", 4'h1);
    read_quad("qread1", 4'h2);
    read_quad("qread2", 4'h3);
    read_quad("qread3", 4'h4);
    stop_txn();
    chk("qread_rd_count", rd_log.size(), 3);
    chk("qread_rd_addr0", {8'd0, rd_log[0]}, 32'h100);
    chk("qread_rd_addr1", {8'd0, rd_log[1]}, 32'h101);
    chk("qread_rd_addr2", {8'd0, rd_log[2]}, 32'h102);
    clear_logs();

    // Quad write 0x38 @0xFFFFFF, 0xDE 0xAD, address wraps
    oe_watch = 1'b1;
    start_txn();
    send_serial(32'h38, 8);
    send_quad(32'hFFFFFF, 6);
    send_quad(32'hDEAD, 4);
    stop_txn();
    chk("qwr_wr_count", wr_addr_log.size(), 2);
    chk("qwr_addr0", {8'd0, wr_addr_log[0]}, 32'hFFFFFF);
    chk("qwr_data0", {24'd0, wr_data_log[0]}, 32'hDE);
    chk("qwr_addr1", {8'd0, wr_addr_log[1]}, 32'h0);
    chk("qwr_data1", {24'd0, wr_data_log[1]}, 32'hAD);
    chk("qwr_rd_count", rd_log.size(), 0);
    chk("qwr_oe_zero", oe_bad, 0);
    clear_logs();

    // Unknown command 0x9F then 32 sck cycles
    start_txn();
    send_serial(32'h9F, 8);
    for (int i = 0; i < 32; i++) sck_cycle(4'(i));
    stop_txn();
    chk("ign_rd_count", rd_log.size(), 0);
    chk("ign_wr_count", wr_addr_log.size(), 0);
    chk("ign_oe_zero", oe_bad, 0);
    clear_logs();

    // Quad write aborted after one data nibble
    start_txn();
    send_serial(32'h38, 8);
    send_quad(32'h000020, 6);
    send_quad(32'h7, 1);
    stop_txn();
    chk("abort_wr_count", wr_addr_log.size(), 0);
    chk("abort_oe_zero", oe_bad, 0);
    oe_watch = 1'b0;
    clear_logs();
    start_txn();
    send_serial(32'h03, 8);
    send_serial(32'h000010, 24);
    read_serial("after_abort", 8'hA5);
    stop_txn();
    chk("after_abort_rd_addr", {8'd0, rd_log[0]}, 32'h10);
    clear_logs();

    // Reset pulsed during RDATA
    start_txn();
    send_serial(32'h03, 8);
    send_serial(32'h000040, 24);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b0;
      wclk(6);
      sck = 1'b1;
      wclk(6);
    end
    chk("mid_rdata_oe", {28'd0, dq_oe}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_oe", {28'd0, dq_oe}, 32'h0);
    wclk(3);
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) sck_cycle(4'h0);
    chk("post_rst_rd_count", rd_log.size(), 0);
    chk("post_rst_wr_count", wr_addr_log.size(), 0);
    chk("post_rst_oe", {28'd0, dq_oe}, 32'h0);
    stop_txn();
    start_txn();
    send_serial(32'h03, 8);
    send_serial(32'h000010, 24);
    read_serial("post_rst", 8'hA5);
    stop_txn();

    chk("never_both_strobes", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
